// File: rtl/noise_histogram.sv
// 128-bin histogram of a signed 8-bit noise stream, with a sequential bin
// readout over valid/ready so the host can compare against the generator CDF.
module noise_histogram #(
  parameter int CNT_W = 16,
  parameter int TOT_W = 32,
  parameter int BIAS  = 63
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             start,
  input  logic [TOT_W-1:0] num_samples,
  input  logic [7:0]       noise_in,
  input  logic             noise_in_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_bin,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [TOT_W-1:0] sample_count,
  output logic [15:0]      oor_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DUMP, DONE} state_t;

  state_t state_reg, state_next;

  logic [TOT_W-1:0] target_reg;
  logic [6:0]       clr_addr_reg;
  logic             s1_valid_reg;
  logic [6:0]       s1_bin_reg;
  logic             fwd_valid_reg;
  logic [6:0]       fwd_bin_reg;
  logic [CNT_W-1:0] fwd_data_reg;
  logic [7:0]       dump_addr_reg;
  logic             rd_pend_reg;
  logic [6:0]       rd_bin_reg;

  logic [CNT_W-1:0] mem [0:127];
  logic [CNT_W-1:0] rd_data_reg;

  logic             start_ok;
  logic             accept;
  logic signed [9:0] v_ext;
  logic signed [9:0] v_sum;
  logic [6:0]       map_bin;
  logic             map_oor;
  logic [CNT_W-1:0] s1_old;
  logic [CNT_W-1:0] s1_new;
  logic             load;
  logic             issue;
  logic             xfer;
  logic             mem_re;
  logic [6:0]       mem_raddr;
  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [CNT_W-1:0] mem_wdata;

  always_comb begin
    start_ok = start && (state_reg == IDLE || state_reg == DONE);
    accept   = (state_reg == ACCUM) && noise_in_valid && en && (sample_count < target_reg);

    v_ext   = {{2{noise_in[7]}}, noise_in};
    v_sum   = v_ext + $signed(10'(BIAS));
    map_bin = v_sum[6:0];
    map_oor = 1'b0;
    if (v_sum < 10'sd0) begin
      map_bin = 7'd0;
      map_oor = 1'b1;
    end else if (v_sum > 10'sd127) begin
      map_bin = 7'd127;
      map_oor = 1'b1;
    end

    // The write from the previous cycle lands after this bin's read, so take it from the bypass.
    s1_old = (fwd_valid_reg && fwd_bin_reg == s1_bin_reg) ? fwd_data_reg : rd_data_reg;
    s1_new = (s1_old == {CNT_W{1'b1}}) ? s1_old : s1_old + CNT_W'(1);

    // Readout: rd_data_reg holds one prefetched bin; refill it only once it has moved to the output.
    load  = (state_reg == DUMP) && rd_pend_reg && (!out_valid || out_ready);
    issue = (state_reg == DUMP) && !dump_addr_reg[7] && (!rd_pend_reg || load);
    xfer  = out_valid && out_ready;

    mem_re    = accept || issue;
    mem_raddr = issue ? dump_addr_reg[6:0] : map_bin;
    mem_we    = (state_reg == CLEAR) || s1_valid_reg;
    mem_waddr = (state_reg == CLEAR) ? clr_addr_reg : s1_bin_reg;
    mem_wdata = (state_reg == CLEAR) ? '0 : s1_new;

    busy = (state_reg == CLEAR) || (state_reg == ACCUM) ||
           (state_reg == DRAIN) || (state_reg == DUMP);
    done = (state_reg == DONE);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start_ok) state_next = CLEAR;
      CLEAR: begin
        if (clr_addr_reg == 7'd127)
          state_next = (target_reg == '0) ? DRAIN : ACCUM;
      end
      ACCUM: if (accept && (sample_count + TOT_W'(1) == target_reg)) state_next = DRAIN;
      DRAIN: if (!s1_valid_reg) state_next = DUMP;
      DUMP:  if (xfer && out_last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      target_reg    <= '0;
      sample_count  <= '0;
      oor_count     <= '0;
      clr_addr_reg  <= '0;
      s1_valid_reg  <= 1'b0;
      s1_bin_reg    <= '0;
      fwd_valid_reg <= 1'b0;
      fwd_bin_reg   <= '0;
      fwd_data_reg  <= '0;
      dump_addr_reg <= '0;
      rd_pend_reg   <= 1'b0;
      rd_bin_reg    <= '0;
      out_valid     <= 1'b0;
      out_bin       <= '0;
      out_count     <= '0;
      out_last      <= 1'b0;
    end else begin
      if (start_ok) begin
        target_reg    <= num_samples;
        sample_count  <= '0;
        oor_count     <= '0;
        clr_addr_reg  <= '0;
        dump_addr_reg <= '0;
        rd_pend_reg   <= 1'b0;
      end

      if (state_reg == CLEAR) clr_addr_reg <= clr_addr_reg + 7'd1;

      if (accept) begin
        sample_count <= sample_count + TOT_W'(1);
        if (map_oor && oor_count != 16'hFFFF) oor_count <= oor_count + 16'd1;
      end

      s1_valid_reg  <= accept;
      s1_bin_reg    <= map_bin;
      fwd_valid_reg <= s1_valid_reg;
      fwd_bin_reg   <= s1_bin_reg;
      fwd_data_reg  <= s1_new;

      if (issue) begin
        dump_addr_reg <= dump_addr_reg + 8'd1;
        rd_bin_reg    <= dump_addr_reg[6:0];
        rd_pend_reg   <= 1'b1;
      end else if (load) begin
        rd_pend_reg <= 1'b0;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_bin   <= rd_bin_reg;
        out_count <= rd_data_reg;
        out_last  <= (rd_bin_reg == 7'd127);
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) rd_data_reg <= mem[mem_raddr];
  end

endmodule

// File: tb/tb_noise_histogram.sv
// Directed bench for noise_histogram (8-bit bins so saturation is reachable).
module tb_noise_histogram;

  localparam int CW = 8;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] num_samples = '0;
  logic [7:0]    noise_in = '0;
  logic          noise_in_valid = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [6:0]    out_bin;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [TW-1:0] sample_count;
  logic [15:0]   oor_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_bins [128];
  int got_bins [128];
  int nx;

  noise_histogram #(.CNT_W(CW), .TOT_W(TW), .BIAS(63)) dut (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .num_samples(num_samples),
    .noise_in(noise_in), .noise_in_valid(noise_in_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_count(out_count), .out_last(out_last), .busy(busy), .done(done),
    .sample_count(sample_count), .oor_count(oor_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_capture(input int n);
    start = 1'b1;
    num_samples = TW'(n);
    step(1);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    step(130);
  endtask

  task automatic feed(input int v, input logic e);
    noise_in = 8'(v);
    noise_in_valid = 1'b1;
    en = e;
    step(1);
  endtask

  task automatic idle_in();
    noise_in_valid = 1'b0;
    en = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 128; i++) exp_bins[i] = 0;
  endtask

  task automatic dump(input string tag, input bit toggle, output int nxfer);
    int cyc = 0;
    int want = 0;
    bit stalled = 1'b0;
    logic [6:0] pb = '0;
    logic [CW-1:0] pc = '0;
    logic pl = 1'b0;
    nxfer = 0;
    for (int i = 0; i < 128; i++) got_bins[i] = -1;
    while (nxfer < 128 && cyc < 2000) begin
      if (stalled) begin
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_bin"}, out_bin, pb);
        check({tag, "_stall_count"}, out_count, pc);
        check({tag, "_stall_last"}, out_last, pl);
      end
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (out_valid && out_ready) begin
        check({tag, "_order"}, out_bin, want);
        check({tag, "_last"}, out_last, (want == 127));
        got_bins[out_bin] = int'(out_count);
        want++;
        nxfer++;
      end
      stalled = out_valid && !out_ready;
      pb = out_bin;
      pc = out_count;
      pl = out_last;
      step(1);
      cyc++;
    end
    out_ready = 1'b1;
    check({tag, "_xfers"}, nxfer, 128);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, out_valid, 0);
    for (int i = 0; i < 128; i++)
      check($sformatf("%s_bin%0d", tag, i), 64'(got_bins[i]), 64'(exp_bins[i]));
  endtask

  initial begin
    // reset state
    step(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sample_count", sample_count, 0);
    check("rst_oor", oor_count, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_last", out_last, 0);
    rstn = 1'b1;
    step(2);

    // 1: edges of the in-range window plus back-to-back same bin
    begin_capture(4);
    feed(-63, 1'b1); feed(0, 1'b1); feed(0, 1'b1); feed(64, 1'b1);
    idle_in();
    clear_exp();
    exp_bins[0] = 1; exp_bins[63] = 2; exp_bins[127] = 1;
    dump("t1", 1'b0, nx);
    check("t1_sample_count", sample_count, 4);
    check("t1_oor", oor_count, 0);

    // 2: saturation of an 8-bit bin with a continuous same-bin stream
    begin_capture(300);
    for (int i = 0; i < 300; i++) feed(5, 1'b1);
    idle_in();
    clear_exp();
    exp_bins[68] = 255;
    dump("t2", 1'b0, nx);
    check("t2_sample_count", sample_count, 300);
    check("t2_oor", oor_count, 0);

    // 3: out-of-range clamping
    begin_capture(3);
    feed(-100, 1'b1); feed(100, 1'b1); feed(-63, 1'b1);
    idle_in();
    clear_exp();
    exp_bins[0] = 2; exp_bins[127] = 1;
    dump("t3", 1'b0, nx);
    check("t3_sample_count", sample_count, 3);
    check("t3_oor", oor_count, 2);

    // 4+5: en gating, target cutoff, and readout under out_ready toggling
    begin_capture(5);
    for (int i = 0; i < 10; i++) feed(-1, 1'b0);
    for (int i = 1; i <= 7; i++) feed(i, 1'b1);
    idle_in();
    clear_exp();
    for (int i = 64; i <= 68; i++) exp_bins[i] = 1;
    dump("t4", 1'b1, nx);
    check("t4_sample_count", sample_count, 5);
    check("t4_oor", oor_count, 0);

    // 6: asynchronous abort mid-accumulation, then a fresh capture
    begin_capture(100);
    for (int i = 0; i < 50; i++) feed(-20, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_sample_count", sample_count, 0);
    check("t6_rst_oor", oor_count, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_last", out_last, 0);
    idle_in();
    step(2);
    rstn = 1'b1;
    step(1);
    begin_capture(2);
    feed(10, 1'b1); feed(10, 1'b1);
    idle_in();
    clear_exp();
    exp_bins[73] = 2;
    dump("t6", 1'b0, nx);
    check("t6_sample_count", sample_count, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
